// File: rtl/turbo_deinterleaver.sv
// QPP (LTE turbo) de-interleaver: scatters one interleaved code block into a bit array
// at addresses PI(i), then streams it back out in original order, one byte per cycle.
module turbo_deinterleaver (
    input  logic       clk,
    input  logic       reset,
    input  logic       vld_in,
    input  logic       cbs,
    input  logic [7:0] data_in,
    output logic       rdy_in,
    input  logic       rdy_out,
    output logic       vld_out,
    output logic [7:0] data_out
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t        state;
    logic          big_q;
    logic [9:0]    cnt;
    logic [9:0]    rd;
    logic [12:0]   pi_q;
    logic [12:0]   g_q;
    logic [6143:0] mem;

    logic          use_big;
    logic [12:0]   k_cur;
    logic [12:0]   two_f2;
    logic [12:0]   pi_c [0:8];
    logic [12:0]   g_c  [0:8];
    logic [9:0]    last_byte;
    logic          accept;

    // (a + b) mod k for a, b < k: one conditional subtract on a 14-bit sum.
    function automatic logic [12:0] mod_add(input logic [12:0] a,
                                            input logic [12:0] b,
                                            input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k})
            s = s - {1'b0, k};
        return s[12:0];
    endfunction

    // In IDLE the first byte seeds the recursion from cbs directly, before big_q is latched.
    always_comb begin
        use_big = (state == IDLE) ? cbs : big_q;
        k_cur   = use_big ? 13'd6144 : 13'd1056;
        two_f2  = use_big ? 13'd960  : 13'd132;
        pi_c[0] = (state == IDLE) ? 13'd0 : pi_q;
        g_c[0]  = (state == IDLE) ? (use_big ? 13'd743 : 13'd83) : g_q;
        for (int j = 0; j < 8; j++) begin
            pi_c[j+1] = mod_add(pi_c[j], g_c[j], k_cur);
            g_c[j+1]  = mod_add(g_c[j], two_f2, k_cur);
        end
    end

    assign last_byte = big_q ? 10'd767 : 10'd131;
    assign accept    = vld_in && rdy_in;

    always_ff @(posedge clk) begin
        if (reset && accept) begin
            for (int j = 0; j < 8; j++)
                mem[pi_c[j]] <= data_in[j];
        end
    end

    always_comb begin
        data_out = 8'd0;
        if (vld_out)
            data_out = mem[{rd, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            big_q   <= 1'b0;
            cnt     <= 10'd0;
            rd      <= 10'd0;
            pi_q    <= 13'd0;
            g_q     <= 13'd0;
            rdy_in  <= 1'b0;
            vld_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_in <= 1'b1;
                    if (accept) begin
                        big_q <= cbs;
                        pi_q  <= pi_c[8];
                        g_q   <= g_c[8];
                        cnt   <= 10'd1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        pi_q <= pi_c[8];
                        g_q  <= g_c[8];
                        cnt  <= cnt + 10'd1;
                        if (cnt == last_byte) begin
                            state   <= DRAIN;
                            rdy_in  <= 1'b0;
                            vld_out <= 1'b1;
                            rd      <= 10'd0;
                        end
                    end
                end
                DRAIN: begin
                    if (rdy_out) begin
                        rd <= rd + 10'd1;
                        if (rd == last_byte) begin
                            state   <= IDLE;
                            vld_out <= 1'b0;
                            rdy_in  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Scoreboard bench for turbo_deinterleaver: directed blocks push expected bytes,
// a negedge monitor pops and compares every output transfer.
module tb_turbo_deinterleaver;

    logic       clk = 1'b0;
    logic       reset;
    logic       vld_in;
    logic       cbs;
    logic [7:0] data_in;
    logic       rdy_in;
    logic       rdy_out;
    logic       vld_out;
    logic [7:0] data_out;

    turbo_deinterleaver dut (
        .clk      (clk),
        .reset    (reset),
        .vld_in   (vld_in),
        .cbs      (cbs),
        .data_in  (data_in),
        .rdy_in   (rdy_in),
        .rdy_out  (rdy_out),
        .vld_out  (vld_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         out_idx  = 0;
    bit         mon_en   = 1'b0;
    bit         bp_en    = 1'b0;
    logic [7:0] sb [$];
    logic       stream [0:6143];
    logic       orig   [0:6143];

    function automatic void chk(string name, int got, int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endfunction

    function automatic int qpp(int i, int k);
        longint f1, f2;
        f1 = (k == 1056) ? 17 : 263;
        f2 = (k == 1056) ? 66 : 480;
        return int'((f1 * i + f2 * i * i) % k);
    endfunction

    task automatic clear_stream();
        for (int i = 0; i < 6144; i++) stream[i] = 1'b0;
    endtask

    // Expected output: zeros except one byte.
    task automatic push_single(input int k, input int idx, input logic [7:0] val);
        for (int r = 0; r < k / 8; r++)
            sb.push_back((r == idx) ? val : 8'h00);
    endtask

    // Build the interleaved stream from orig and queue orig as the expected output.
    task automatic prep_round_trip(input int k, input int seed);
        for (int i = 0; i < k; i++)
            orig[i] = logic'((((i * 13) ^ (i >> 2) ^ seed) % 7) < 3);
        for (int i = 0; i < k; i++)
            stream[i] = orig[qpp(i, k)];
        for (int r = 0; r < k / 8; r++) begin
            logic [7:0] b;
            for (int j = 0; j < 8; j++) b[j] = orig[8 * r + j];
            sb.push_back(b);
        end
    endtask

    task automatic send_block(input logic c, input int k, input int nbytes, input bit gaps);
        int nb;
        int to;
        nb = k / 8;
        for (int n = 0; n < nbytes; n++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    vld_in = 1'b0;
                    @(posedge clk); #1;
                end
            end
            vld_in = 1'b1;
            cbs    = (n == 0) ? c : ~c;
            for (int j = 0; j < 8; j++) data_in[j] = stream[8 * n + j];
            to = 0;
            @(negedge clk);
            while (!rdy_in && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (!rdy_in) begin
                chk("rdy_in_timeout", 0, 1);
                vld_in = 1'b0;
                return;
            end
            if (n == nb - 1) chk("vld_out_before_last", int'(vld_out), 0);
            @(posedge clk); #1;
        end
        vld_in = 1'b0;
        if (nbytes == nb) begin
            chk("vld_out_latency", int'(vld_out), 1);
            chk("rdy_in_in_drain", int'(rdy_in), 0);
        end
    endtask

    task automatic wait_drain(input bit pulses);
        int to;
        to = 0;
        while (vld_out && to < 20000) begin
            if (pulses) begin
                vld_in  = 1'($urandom_range(0, 1));
                data_in = 8'($urandom);
                cbs     = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            to++;
        end
        vld_in = 1'b0;
        chk("drain_done", int'(vld_out), 0);
        chk("rdy_in_after_drain", int'(rdy_in), 1);
        chk("scoreboard_empty", sb.size(), 0);
        sb.delete();
    endtask

    // Output backpressure generator.
    initial begin
        rdy_out = 1'b1;
        forever begin
            @(posedge clk); #1;
            rdy_out = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compare transfers, check hold stability and data_out=0 when idle.
    initial begin
        logic       held;
        logic [7:0] held_data;
        held = 1'b0;
        held_data = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en && reset) begin
                if (held && vld_out)
                    chk("hold_stable", int'(data_out), int'(held_data));
                if (!vld_out)
                    chk("data_out_zero_idle", int'(data_out), 0);
                if (vld_out && rdy_out) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        chk($sformatf("data_out[%0d]", out_idx), int'(data_out), int'(sb.pop_front()));
                        out_idx++;
                    end
                end
                held = vld_out && !rdy_out;
                held_data = data_out;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        vld_in  = 1'b0;
        cbs     = 1'b0;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy_in", int'(rdy_in), 0);
        chk("reset_vld_out", int'(vld_out), 0);
        chk("reset_data_out", int'(data_out), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("release_rdy_in", int'(rdy_in), 1);
        chk("release_vld_out", int'(vld_out), 0);
        mon_en = 1'b1;

        // K=1056, stream bit 1 -> original bit 83 (byte 10 = 0x08).
        clear_stream();
        stream[1] = 1'b1;
        out_idx = 0;
        push_single(1056, 10, 8'h08);
        send_block(1'b0, 1056, 132, 1'b0);
        wait_drain(1'b0);

        // K=6144, stream bit 2 -> original bit 2446 (byte 305 = 0x40); back-to-back.
        clear_stream();
        stream[2] = 1'b1;
        out_idx = 0;
        push_single(6144, 305, 8'h40);
        send_block(1'b1, 6144, 768, 1'b0);
        wait_drain(1'b0);

        // K=6144, stream bit 0 -> original bit 0 (byte 0 = 0x01).
        clear_stream();
        stream[0] = 1'b1;
        out_idx = 0;
        push_single(6144, 0, 8'h01);
        send_block(1'b1, 6144, 768, 1'b0);
        wait_drain(1'b0);

        // Round trip K=1056, no stalls.
        out_idx = 0;
        prep_round_trip(1056, 5);
        send_block(1'b0, 1056, 132, 1'b0);
        wait_drain(1'b0);

        // Same block with input gaps, output backpressure and vld_in pulses in DRAIN.
        out_idx = 0;
        prep_round_trip(1056, 5);
        bp_en = 1'b1;
        send_block(1'b0, 1056, 132, 1'b1);
        wait_drain(1'b1);
        bp_en = 1'b0;

        // Round trip K=6144 with stalls on both sides.
        out_idx = 0;
        prep_round_trip(6144, 9);
        bp_en = 1'b1;
        send_block(1'b1, 6144, 768, 1'b1);
        wait_drain(1'b0);
        bp_en = 1'b0;

        // Reset mid-LOAD after 50 bytes of a K=1056 block.
        prep_round_trip(1056, 3);
        sb.delete();
        send_block(1'b0, 1056, 50, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midreset_rdy_in", int'(rdy_in), 0);
        chk("midreset_vld_out", int'(vld_out), 0);
        chk("midreset_data_out", int'(data_out), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_release_rdy_in", int'(rdy_in), 1);
        chk("midreset_release_vld_out", int'(vld_out), 0);

        // Fresh K=6144 block after the abort; cbs comes from its first byte.
        out_idx = 0;
        prep_round_trip(6144, 11);
        send_block(1'b1, 6144, 768, 1'b0);
        wait_drain(1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/turbo_deinterleaver.md
# turbo_deinterleaver

QPP (LTE turbo internal) de-interleaver, the receive-side inverse of the team's `interleaver` block. It accepts one code block of interleaved bits as a byte stream and stores each bit at its QPP address Π(i). It then streams the block out in original (pre-interleave) order. The block sits between the channel/decoder front end and CRC check, and supports two code block sizes selected per block by `cbs`.

## Interface
- No parameters. Supported sizes are fixed: `cbs`=0 → K=1056 (f1=17, f2=66); `cbs`=1 → K=6144 (f1=263, f2=480).
- `clk` in 1 — single clock, all logic on rising edge.
- `reset` in 1 — synchronous, active-low (`reset`=0 resets on the next rising edge).
- `vld_in` in 1 — upstream byte valid.
- `cbs` in 1 — code block size select; sampled only with the first byte of a block.
- `data_in` in 8 — interleaved bits; `data_in[j]` = stream bit 8n+j (LSB first).
- `rdy_in` out 1 — block can accept a byte this cycle.
- `rdy_out` in 1 — downstream ready.
- `vld_out` out 1 — `data_out` holds a valid de-interleaved byte.
- `data_out` out 8 — `data_out[j]` = original bit 8r+j.

## Operation
- Storage: 6144-bit flop array `mem`; only bits 0..K-1 are used. No clear on reset.
- Address recursion, no multipliers:
  - Π(0)=0, g(0)=(f1+f2) mod K.
  - Π(i+1)=(Π(i)+g(i)) mod K; g(i+1)=(g(i)+2f2) mod K.
  - 2f2 mod K = 132 (K=1056) / 960 (K=6144); g(0) = 83 / 743.
  - Every operand is < K, so each mod is a single conditional subtract of K. Use 13-bit arithmetic with a 14-bit sum before the compare.
  - Per accepted byte, 8 recursion steps are chained combinationally from the registered (Π, g). Bit j of the byte is written to `mem[Π(8n+j)]`, and (Π(8n+8), g(8n+8)) is registered.
- FSM states:
  - IDLE: `rdy_in`=1. On `vld_in`:
    - latch K, f-constants from `cbs`;
    - write byte 0 using Π(0)=0, g(0);
    - set `cnt`=1 and go to LOAD.
  - LOAD: `rdy_in`=1. Each `vld_in` cycle writes one byte and increments `cnt`. Cycles with `vld_in`=0 are stalls with no state change. When the byte with `cnt`=K/8-1 (131 / 767) is accepted, go to DRAIN and set `rd`=0.
  - DRAIN: `rdy_in`=0, `vld_out`=1, `data_out`=`mem[8rd+7 : 8rd]`.
    - On `rdy_out`=1 the byte is consumed and `rd` increments.
    - When byte K/8-1 is consumed, go to IDLE.
    - `vld_in` is ignored in DRAIN; `cbs` is ignored after the first byte.
- `data_out`=0 whenever `vld_out`=0.
- Single buffer: a new block is not accepted until the previous block has fully drained.

## Timing
- Reset (`reset`=0 at a rising edge) forces state IDLE, `cnt`=0, `rd`=0, Π=0, g=0.
- While `reset` is held low: `rdy_in`=0, `vld_out`=0, `data_out`=0.
- First cycle after release: `rdy_in`=1.
- Reset mid-LOAD or mid-DRAIN aborts the block. Partial data is discarded, with no output on release.
- Input handshake: a byte transfers on a rising edge with `rdy_in`=1 and `vld_in`=1. `rdy_in` is a pure function of state (Moore).
- Latency: `vld_out` rises the cycle after the last input byte is accepted. Output byte r is presented when `rd`=r and holds stable until consumed.
- Output handshake: a transfer occurs on a rising edge with `vld_out`=1 and `rdy_out`=1. With `rdy_out` held high, K/8 bytes leave in K/8 consecutive cycles.
- Wrap-around: after the last output transfer, `vld_out`=0 and `rdy_in`=1 in the next cycle. The minimum block period is K/8 + K/8 cycles.
- Counters: `cnt` and `rd` are 10 bits (max 767).

## Test plan
- Single-bit map, K=1056: stream bit 1 = 1, all others 0 (`data_in`=8'h02 first byte, then zeros) → output bit 83 = 1 only, i.e. byte 10 = 8'h08, all other bytes 8'h00.
- Single-bit map, K=6144 (`cbs`=1): stream bit 2 = 1 → only output bit 2446 set (byte 305 = 8'h40). Stream bit 0 = 1 → only output bit 0 set (byte 0 = 8'h01).
- Round trip, K=1056: feed the team's `interleaver` golden output vector for the standard 1056-bit test block → de-interleaved output equals the original input vector bit-for-bit; `vld_out` asserts exactly 1 cycle after byte 131 is accepted.
- Backpressure/stalls: random `vld_in` gaps during LOAD and random `rdy_out`=0 during DRAIN → identical output to the no-stall run. `data_out` is stable while `vld_out`=1 and `rdy_out`=0. `vld_in` pulses during DRAIN are ignored.
- Reset mid-block: assert `reset`=0 at LOAD byte 50 → next cycle `rdy_in`=0, `vld_out`=0; after release, a fresh K=6144 block runs correctly, with `cbs` taken from its first byte.
- Back-to-back blocks: K=1056 then K=6144 with `rdy_out`=1 → `rdy_in` returns 1 the cycle after the 132nd output byte; the second block outputs 768 correct bytes.
